// File: rtl/processor_config.sv
// Shared beat widths of the axis_processor core and the blocks wrapped around it.
package processor_config;
  localparam int INP_WIDTH = 8;
  localparam int OUT_WIDTH = 8;
endpackage

// File: rtl/axis_proc_arbiter.sv
// Round-robin, packet-granular sharing of one processor among N_REQ streams; responses are steered back by an ID FIFO.
// Command and response paths are combinational (1-cycle grant latency, one bubble per packet); full ID FIFO stalls commands.
module axis_proc_arbiter #(
  parameter int N_REQ       = 4,
  parameter int INP_WIDTH   = processor_config::INP_WIDTH,
  parameter int OUT_WIDTH   = processor_config::OUT_WIDTH,
  parameter int RSP_PER_CMD = 1,
  parameter int ID_DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic [N_REQ*INP_WIDTH-1:0] s_axis_tdata,
  input  logic [N_REQ-1:0]           s_axis_tvalid,
  input  logic [N_REQ-1:0]           s_axis_tlast,
  output logic [N_REQ-1:0]           s_axis_tready,
  output logic [INP_WIDTH-1:0]       p_cmd_tdata,
  output logic                       p_cmd_tvalid,
  input  logic                       p_cmd_tready,
  input  logic [OUT_WIDTH-1:0]       p_rsp_tdata,
  input  logic                       p_rsp_tvalid,
  output logic                       p_rsp_tready,
  output logic [N_REQ*OUT_WIDTH-1:0] m_axis_tdata,
  output logic [N_REQ-1:0]           m_axis_tvalid,
  input  logic [N_REQ-1:0]           m_axis_tready,
  output logic                       err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(ID_DEPTH);
  localparam int BW  = (RSP_PER_CMD > 1) ? $clog2(RSP_PER_CMD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] last;
  logic [IDW-1:0] nxt;
  logic [IDW-1:0] cand;
  logic           nxt_found;
  logic [IDW-1:0] id_mem [ID_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    cnt;
  logic [BW-1:0]  beat;
  logic           empty;
  logic           full;
  logic           bypass;
  logic           head_vld;
  logic [IDW-1:0] head;
  logic           cmd_hs;
  logic           rsp_hs;
  logic           done;
  logic           push;
  logic           pop;

  // First valid requester after the last one served, wrapping around.
  always_comb begin
    nxt       = last;
    nxt_found = 1'b0;
    cand      = last;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last) + k) % N_REQ);
      if (!nxt_found && s_axis_tvalid[cand]) begin
        nxt       = cand;
        nxt_found = 1'b1;
      end
    end
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == (PW+1)'(ID_DEPTH));

  always_comb begin
    s_axis_tready = '0;
    p_cmd_tvalid  = 1'b0;
    p_cmd_tdata   = '0;
    if (state == GRANT) begin
      p_cmd_tdata        = s_axis_tdata[gnt*INP_WIDTH +: INP_WIDTH];
      p_cmd_tvalid       = s_axis_tvalid[gnt] && !full;
      s_axis_tready[gnt] = p_cmd_tready && !full;
    end
  end

  // Bypass lets a zero-latency processor answer the command it is accepting right now.
  assign bypass       = empty && (state == GRANT) && s_axis_tvalid[gnt] && !full;
  assign head_vld     = !empty || bypass;
  assign head         = empty ? gnt : id_mem[rd_ptr];
  assign p_rsp_tready = head_vld && m_axis_tready[head];
  assign m_axis_tdata = {N_REQ{p_rsp_tdata}};

  always_comb begin
    m_axis_tvalid = '0;
    if (head_vld)
      m_axis_tvalid[head] = p_rsp_tvalid;
  end

  assign cmd_hs = p_cmd_tvalid && p_cmd_tready;
  assign rsp_hs = p_rsp_tvalid && p_rsp_tready;
  assign done   = rsp_hs && (beat == BW'(RSP_PER_CMD - 1));
  assign pop    = done && !empty;
  assign push   = cmd_hs && !(done && empty);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state  <= IDLE;
      gnt    <= '0;
      last   <= IDW'(N_REQ - 1);
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      beat   <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (nxt_found) begin
          gnt   <= nxt;
          state <= GRANT;
        end
        GRANT: if (cmd_hs && s_axis_tlast[gnt]) begin
          last  <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      if (rsp_hs)
        beat <= done ? '0 : beat + BW'(1);
      // A completed response with nobody on record to own it.
      if (done && empty && !cmd_hs)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      id_mem[wr_ptr] <= gnt;
  end

endmodule
